// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI mode-0 target: FSM encoding and byte geometry.
// No logic, no latency.
// No flow control of its own.
package spi_target_pkg;

  localparam int         BITS_PER_BYTE = 8;
  localparam int         BIT_W         = $clog2(BITS_PER_BYTE);
  localparam logic [7:0] IDLE_BYTE_DEF = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_target_sync.sv
// Single-bit synchroniser: STAGES-flop chain, clears asynchronously to CLEAR_VAL.
// Latency: STAGES clocks.
// No backpressure; samples every clock.
module spi_target_sync #(
  parameter int   STAGES    = 2,
  parameter logic CLEAR_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous pin through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= {STAGES{CLEAR_VAL}};
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled SCK/nSS/MOSI, MSB-first byte streams on valid/ready.
// Latency: nSS fall to MISO_OE and 8th SCK rise to rx_valid are SYNC_STAGES+2 CLKs.
// RX full at byte end drops the byte (overrun); empty TX at load sends fill byte (underrun).
// Optional SPITGT_ECHO_EN: fill byte is the last completed RX byte instead of IDLE_BYTE.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEF
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       SCK,
  input  logic       nSS,
  input  logic       MOSI,
  output logic       MISO,
  output logic       MISO_OE,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       overrun,
  output logic       underrun
);

  logic sck_s, nss_s, mosi_s;
  logic sck_d, nss_d;
  logic sck_rise, sck_fall, nss_rise, nss_fall;

  state_t state, state_nxt;
  logic   load_now, go_idle;

  logic [BIT_W-1:0] bitcnt;
  logic [7:0]       tx_shift, rx_shift;
  logic             byte_done;
  logic [7:0]       hold_dat;
  logic             hold_full;
  logic             tx_accept;
  logic [7:0]       fill_byte, load_byte;

  spi_target_sync #(.STAGES(SYNC_STAGES), .CLEAR_VAL(1'b0)) u_sync_sck
    (.clk(CLK), .rst_n(nRESET), .d(SCK),  .q(sck_s));
  spi_target_sync #(.STAGES(SYNC_STAGES), .CLEAR_VAL(1'b1)) u_sync_nss
    (.clk(CLK), .rst_n(nRESET), .d(nSS),  .q(nss_s));
  spi_target_sync #(.STAGES(SYNC_STAGES), .CLEAR_VAL(1'b0)) u_sync_mosi
    (.clk(CLK), .rst_n(nRESET), .d(MOSI), .q(mosi_s));

  // One extra flop on SCK and nSS for edge detection.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      sck_d <= 1'b0;
      nss_d <= 1'b1;
    end else begin
      sck_d <= sck_s;
      nss_d <= nss_s;
    end
  end

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign nss_rise = nss_s & ~nss_d;
  assign nss_fall = ~nss_s & nss_d;

  // FSM state register.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state; a shifter load happens in LOAD and on the SCK fall at a byte boundary.
  always_comb begin
    state_nxt = state;
    load_now  = 1'b0;
    go_idle   = 1'b0;
    case (state)
      ST_IDLE:  if (nss_fall) state_nxt = ST_LOAD;
      ST_LOAD: begin
        load_now  = 1'b1;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: if (sck_fall && bitcnt == '0) load_now = 1'b1;
      default:  state_nxt = ST_IDLE;
    endcase
    // Deselect wins over everything, including a coincident load.
    if (nss_rise) begin
      state_nxt = ST_IDLE;
      load_now  = 1'b0;
      go_idle   = 1'b1;
    end
  end

  // tx_ready also rises during a load so a new byte can enter as the old one leaves.
  assign tx_ready  = ~hold_full | load_now;
  assign tx_accept = tx_valid & tx_ready;

`ifdef SPITGT_ECHO_EN
  logic [7:0] last_rx;

  // Remember every completed RX byte, dropped ones included, for echo.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET)        last_rx <= IDLE_BYTE;
    else if (byte_done) last_rx <= rx_shift;
  end

  assign fill_byte = last_rx;
`else
  assign fill_byte = IDLE_BYTE;
`endif

  assign load_byte = hold_full ? hold_dat : fill_byte;

  // TX holding register: filled by the handshake, emptied by a shifter load.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      hold_dat  <= 8'h00;
      hold_full <= 1'b0;
    end else if (tx_accept) begin
      hold_dat  <= tx_data;
      hold_full <= 1'b1;
    end else if (load_now) begin
      hold_full <= 1'b0;
    end
  end

  // Shift engine: RX on SCK rise, TX on SCK fall, reload at byte boundaries.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      tx_shift  <= 8'hFF;
      rx_shift  <= 8'h00;
      bitcnt    <= '0;
      byte_done <= 1'b0;
      MISO_OE   <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      underrun  <= 1'b0;
      if (go_idle) begin
        tx_shift <= 8'hFF;
        bitcnt   <= '0;
        MISO_OE  <= 1'b0;
        busy     <= 1'b0;
      end else if (load_now) begin
        tx_shift <= load_byte;
        underrun <= ~hold_full;
        MISO_OE  <= 1'b1;
        busy     <= 1'b1;
      end else if (state == ST_SHIFT) begin
        if (sck_rise) begin
          rx_shift  <= {rx_shift[6:0], mosi_s};
          bitcnt    <= bitcnt + BIT_W'(1);
          byte_done <= (bitcnt == BIT_W'(BITS_PER_BYTE - 1));
        end else if (sck_fall) begin
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

  assign MISO = tx_shift[7];

  // RX output register: accept a finished byte if empty or being popped, else flag overrun.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (byte_done && (!rx_valid || rx_ready)) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end else begin
        if (rx_ready) rx_valid <= 1'b0;
        if (byte_done) overrun <= 1'b1;
      end
    end
  end

endmodule
